// File: rtl/adc_scan_sequencer.sv
// Multi-channel ADC scan sequencer: masked one-shot/continuous scans with a valid/ready output stage.
// Optional 4x averaging per channel when ADC_SEQ_AVG_EN is defined.
module adc_scan_sequencer #(
    parameter int DATA_W      = 16,
    parameter int NUM_CH      = 4,
    parameter int CONV_CYCLES = 2,
    parameter int CH_W        = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cont_mode,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic [DATA_W-1:0] adc_in,
    output logic [CH_W-1:0]   adc_ch_sel,
    output logic              adc_sample,
    output logic [DATA_W-1:0] out_data,
    output logic [CH_W-1:0]   out_ch,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              scan_done,
    output logic              overrun
);

    localparam int CNT_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SELECT,
        S_WAIT,
        S_CAPTURE
    } state_t;

    state_t            state;
    logic [NUM_CH-1:0] scan_mask;
    logic [CH_W-1:0]   cur_ch;
    logic [CNT_W-1:0]  wait_cnt;

    logic [CH_W-1:0]   launch_ch;
    logic              launch_found;
    logic [CH_W-1:0]   next_ch;
    logic              next_found;
    logic              last_rep;
    logic [DATA_W-1:0] cap_data;

`ifdef ADC_SEQ_AVG_EN
    logic [DATA_W+1:0] accum;
    logic [DATA_W+1:0] accum_sum;
    logic [1:0]        rep;
`endif

    // Lowest set bit of the live mask (launch) and next higher bit of the latched mask.
    always_comb begin
        launch_ch    = '0;
        launch_found = 1'b0;
        next_ch      = '0;
        next_found   = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (ch_mask[CH_W'(i)] && !launch_found) begin
                launch_ch    = CH_W'(i);
                launch_found = 1'b1;
            end
            if (scan_mask[CH_W'(i)] && (CH_W'(i) > cur_ch) && !next_found) begin
                next_ch    = CH_W'(i);
                next_found = 1'b1;
            end
        end
    end

`ifdef ADC_SEQ_AVG_EN
    always_comb begin
        accum_sum = accum + {2'b00, adc_in};
        last_rep  = (rep == 2'd3);
        cap_data  = accum_sum[DATA_W+1:2];
    end
`else
    always_comb begin
        last_rep = 1'b1;
        cap_data = adc_in;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            scan_mask  <= '0;
            cur_ch     <= '0;
            wait_cnt   <= '0;
            adc_ch_sel <= '0;
            adc_sample <= 1'b0;
            out_data   <= '0;
            out_ch     <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            scan_done  <= 1'b0;
            overrun    <= 1'b0;
`ifdef ADC_SEQ_AVG_EN
            accum      <= '0;
            rep        <= '0;
`endif
        end else begin
            adc_sample <= 1'b0;
            scan_done  <= 1'b0;
            if (out_valid && out_ready)
                out_valid <= 1'b0;

            case (state)
                S_IDLE: begin
                    // Gating on scan_done makes a start in the scan_done cycle a no-op.
                    if ((start || cont_mode) && (ch_mask != '0) && !scan_done) begin
                        scan_mask  <= ch_mask;
                        cur_ch     <= launch_ch;
                        adc_ch_sel <= launch_ch;
                        adc_sample <= 1'b1;
                        overrun    <= 1'b0;
                        busy       <= 1'b1;
                        state      <= S_SELECT;
`ifdef ADC_SEQ_AVG_EN
                        accum      <= '0;
                        rep        <= '0;
`endif
                    end
                end

                S_SELECT: begin
                    wait_cnt <= CNT_W'(CONV_CYCLES - 1);
                    state    <= S_WAIT;
                end

                S_WAIT: begin
                    if (wait_cnt == '0)
                        state <= S_CAPTURE;
                    else
                        wait_cnt <= wait_cnt - 1'b1;
                end

                S_CAPTURE: begin
`ifdef ADC_SEQ_AVG_EN
                    accum <= last_rep ? '0 : accum_sum;
                    rep   <= rep + 1'b1;
`endif
                    if (last_rep) begin
                        if (!out_valid || out_ready) begin
                            out_data  <= cap_data;
                            out_ch    <= cur_ch;
                            out_valid <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end

                    if (!last_rep) begin
                        adc_sample <= 1'b1;
                        state      <= S_SELECT;
                    end else if (next_found) begin
                        cur_ch     <= next_ch;
                        adc_ch_sel <= next_ch;
                        adc_sample <= 1'b1;
                        state      <= S_SELECT;
                    end else begin
                        scan_done <= 1'b1;
                        if (cont_mode && (ch_mask != '0)) begin
                            scan_mask  <= ch_mask;
                            cur_ch     <= launch_ch;
                            adc_ch_sel <= launch_ch;
                            adc_sample <= 1'b1;
                            state      <= S_SELECT;
                        end else begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/adc_scan_sequencer.md
# adc_scan_sequencer

Parametrised multi-channel successor to the single-channel ADC capture block. It drives an external ADC's channel mux and start-of-conversion strobe, and scans a masked set of channels in one-shot or continuous mode. It waits a configurable conversion time, then captures each result into a valid/ready output stage tagged with its channel number. It sits between the analogue front-end pins and the sample-processing datapath.

## Interface
- DATA_W, 16, ADC result width.
- NUM_CH, 4, number of ADC channels (2..16).
- CONV_CYCLES, 2, cycles between the start strobe and a valid `adc_in` (≥1).
- CH_W, $clog2(NUM_CH), channel index width (derived).

- clk  in  1  system clock, all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  launches one scan when idle; ignored while busy.
- cont_mode  in  1  1 = rescan forever; sampled at each scan end.
- ch_mask  in  NUM_CH  enabled channels; latched at scan launch.
- adc_in  in  DATA_W  conversion result from the ADC.
- adc_ch_sel  out  CH_W  channel mux select to the ADC.
- adc_sample  out  1  one-cycle start-of-conversion strobe.
- out_data  out  DATA_W  captured sample.
- out_ch  out  CH_W  channel of `out_data`.
- out_valid  out  1  output holds an unconsumed sample.
- out_ready  in  1  consumer accepts when `out_valid & out_ready`.
- busy  out  1  high whenever state ≠ IDLE.
- scan_done  out  1  one-cycle pulse after the last channel of a scan is captured.
- overrun  out  1  sticky flag: a sample was dropped.

## Operation
- Reset forces IDLE, and every output to 0: `adc_ch_sel`, `adc_sample`, `out_data`, `out_ch`, `out_valid`, `busy`, `scan_done`, `overrun`.
- IDLE: on `start | cont_mode` with `ch_mask ≠ 0`, the block latches the mask, selects its lowest set bit, clears `overrun`, and goes to SELECT. A zero mask is ignored and the block stays in IDLE.
- SELECT (1 cycle): drives `adc_ch_sel` = current channel, pulses `adc_sample`, loads the wait counter, then goes to WAIT.
- WAIT (exactly CONV_CYCLES cycles), then CAPTURE.
- CAPTURE (1 cycle):
  - If the output slot is free (`!out_valid`, or `out_ready` in this cycle), it loads `out_data` = `adc_in`, `out_ch` = channel, and sets `out_valid`.
  - Otherwise it drops the sample and sets `overrun`; the old output is held.
  - It then advances to the next higher set bit in the latched mask and goes to SELECT.
  - If no higher bit is set, it pulses `scan_done`. With `cont_mode` = 1 it relaunches from the lowest set bit of the current `ch_mask` (SELECT; `overrun` not cleared). Otherwise it returns to IDLE.
- Output stage: `out_valid` clears on `out_valid & out_ready` unless a capture reloads it in the same cycle, in which case it stays 1 with the new data.
- Mid-scan `ch_mask`/`cont_mode` changes do not affect the current scan.
- `adc_ch_sel` holds its value between SELECTs.

## Timing
- `start` is sampled at edge 0. `adc_sample` is high in cycle 1, CAPTURE is cycle 2+CONV_CYCLES, and `out_valid` is high from cycle 3+CONV_CYCLES (cycle 5 at defaults).
- Per-channel period is CONV_CYCLES+2 cycles, so one scan of k channels takes k·(CONV_CYCLES+2) cycles.
- `scan_done` is asserted in the cycle after the final CAPTURE, coincident with the final `out_valid` rise.
- `start` asserted in the same cycle as `scan_done` with `cont_mode` = 0 is ignored; the next scan is accepted from IDLE one cycle later.
- `rst` mid-scan aborts immediately; any pending output is discarded.

## Configuration
- `ADC_SEQ_AVG_EN` defined:
  - Each enabled channel is converted 4 times back to back (SELECT/WAIT/accumulate ×4), using a DATA_W+2-bit accumulator cleared per channel.
  - The output is `accum[DATA_W+1:2]` (truncating mean).
  - The slot/overrun check and `out_valid` happen only on the 4th capture.
  - Per-channel period becomes 4·(CONV_CYCLES+2).
- Undefined: a single conversion per channel, raw sample output, no accumulator logic.

## Test plan
- Reset mid-WAIT → all outputs 0 next cycle, `busy` = 0, no `out_valid` after release.
- `ch_mask` = 4'b1010, `start` pulse, `out_ready` = 1, `adc_in` = 16'h1234 → two outputs, `out_ch` = 1 then 3, data 16'h1234, `out_valid` first high at cycle 5, one `scan_done` pulse, return to IDLE.
- `ch_mask` = 0 with `start` → `busy` stays 0, no `adc_sample`.
- `ch_mask` = 4'b1111, `out_ready` = 0 → first sample (ch0) held, `overrun` = 1 after ch1 CAPTURE, `out_ch` remains 0. Then `start` after IDLE → `overrun` cleared.
- `cont_mode` = 1, mask 4'b0001 → `adc_sample` every 4 cycles and `scan_done` every 4 cycles. Dropping `cont_mode` → IDLE after the current capture.
- With `ADC_SEQ_AVG_EN`, `adc_in` sequence 10, 20, 30, 41 on ch0 → `out_data` = 25, 16 cycles per channel.
